// File: rtl/change_dispense_ctrl_pkg.sv
// Shared constants, coin values and FSM encoding for the change dispenser.
// Optional hopper timeout is enabled with `define CHANGE_DISPENSE_TIMEOUT_EN.
package change_dispense_ctrl_pkg;

    localparam int CD_TOTAL_BITS = 31;
    localparam int CD_NUM_COINS  = 3;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SELECT   = 2'd1,
        ST_DISPENSE = 2'd2,
        ST_DONE     = 2'd3
    } state_t;

    // Denomination index 0 is the smallest coin; the one-hot select uses the same order.
    function automatic logic [31:0] coin_value(input int idx);
        case (idx)
            0:       coin_value = 32'd100;
            1:       coin_value = 32'd500;
            default: coin_value = 32'd1000;
        endcase
    endfunction

endpackage

// File: rtl/change_dispense_ctrl_coin_pick.sv
// Greedy selector: highest denomination that is in stock and not larger than
// the remaining amount. Purely combinational.
module change_coin_pick
    import change_dispense_ctrl_pkg::*;
#(
    parameter int TOTAL_BITS = CD_TOTAL_BITS,
    parameter int NUM_COINS  = CD_NUM_COINS,
    parameter int INV_BITS   = 8
) (
    input  logic [TOTAL_BITS-1:0]         remaining,
    input  logic [NUM_COINS*INV_BITS-1:0] inv_flat,
    output logic [NUM_COINS-1:0]          pick,
    output logic                          found
);

    logic [NUM_COINS-1:0] qual;

    generate
        for (genvar gi = 0; gi < NUM_COINS; gi++) begin : g_qual
            assign qual[gi] = (inv_flat[gi*INV_BITS +: INV_BITS] != '0) &&
                              (remaining >= TOTAL_BITS'(coin_value(gi)));
        end
    endgenerate

    // Ascending scan so the last qualifying (largest) coin wins.
    always_comb begin
        pick  = '0;
        found = |qual;
        for (int i = 0; i < NUM_COINS; i++) begin
            if (qual[i]) begin
                pick    = '0;
                pick[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/change_dispense_ctrl.sv
// Change payout sequencer: greedy coin selection, hopper valid/ack handshake,
// per-denomination inventory. Optional timeout: CHANGE_DISPENSE_TIMEOUT_EN.
module change_dispense_ctrl
    import change_dispense_ctrl_pkg::*;
#(
    parameter int TOTAL_BITS     = CD_TOTAL_BITS,
    parameter int NUM_COINS      = CD_NUM_COINS,
    parameter int INV_BITS       = 8,
    parameter int INIT_INV       = 10,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic [TOTAL_BITS-1:0] i_req_amount,
    output logic                  o_hop_valid,
    output logic [NUM_COINS-1:0]  o_hop_sel,
    input  logic                  i_hop_ack,
    input  logic                  i_refill_valid,
    input  logic [NUM_COINS-1:0]  i_refill_sel,
    input  logic [INV_BITS-1:0]   i_refill_count,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [TOTAL_BITS-1:0] o_shortfall,
    output logic [NUM_COINS-1:0]  o_inv_empty,
    output logic                  o_hop_fault
);

    localparam logic [INV_BITS:0] INV_MAX = {1'b0, {INV_BITS{1'b1}}};
    localparam logic [INV_BITS:0] ONE_W   = {{INV_BITS{1'b0}}, 1'b1};

    state_t                        state_reg;
    logic [TOTAL_BITS-1:0]         remaining_reg;
    logic                          hop_valid_reg;
    logic [NUM_COINS-1:0]          hop_sel_reg;
    logic                          req_ready_reg;
    logic                          busy_reg;
    logic                          done_reg;
    logic [TOTAL_BITS-1:0]         shortfall_reg;

    logic [NUM_COINS*INV_BITS-1:0] inv_flat;
    logic [NUM_COINS-1:0]          pick;
    logic                          found;
    logic [TOTAL_BITS-1:0]         sel_value;
    logic                          ack_take;
    logic                          refill_ok;
    logic                          jam;

    assign ack_take  = (state_reg == ST_DISPENSE) && i_hop_ack;
    assign refill_ok = i_refill_valid && $onehot(i_refill_sel);

`ifdef CHANGE_DISPENSE_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0] tmo_cnt_reg;
    logic             hop_fault_reg;

    assign jam = (state_reg == ST_DISPENSE) && !i_hop_ack &&
                 (tmo_cnt_reg == TMO_W'(TIMEOUT_CYCLES - 1));

    // Counter sits at zero outside DISPENSE, so each coin starts a fresh window.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            tmo_cnt_reg   <= '0;
            hop_fault_reg <= 1'b0;
        end else begin
            hop_fault_reg <= jam;
            if (state_reg != ST_DISPENSE || jam) begin
                tmo_cnt_reg <= '0;
            end else begin
                tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
            end
        end
    end

    assign o_hop_fault = hop_fault_reg;
`else
    assign jam         = 1'b0;
    assign o_hop_fault = 1'b0;
`endif

    generate
        for (genvar gi = 0; gi < NUM_COINS; gi++) begin : g_inv
            logic [INV_BITS-1:0] inv_reg;
            logic [INV_BITS:0]   inv_sum;

            // One extra bit catches refill overflow; the ack decrement never
            // borrows because a coin is only issued from non-empty stock.
            always_comb begin
                inv_sum = {1'b0, inv_reg};
                if (refill_ok && i_refill_sel[gi]) begin
                    inv_sum = inv_sum + {1'b0, i_refill_count};
                end
                if (ack_take && hop_sel_reg[gi]) begin
                    inv_sum = inv_sum - ONE_W;
                end
            end

            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    inv_reg <= INV_BITS'(INIT_INV);
                end else if (jam && hop_sel_reg[gi]) begin
                    inv_reg <= '0;
                end else if (inv_sum > INV_MAX) begin
                    inv_reg <= '1;
                end else begin
                    inv_reg <= inv_sum[INV_BITS-1:0];
                end
            end

            assign inv_flat[gi*INV_BITS +: INV_BITS] = inv_reg;
            assign o_inv_empty[gi] = (inv_reg == '0);
        end
    endgenerate

    change_coin_pick #(
        .TOTAL_BITS (TOTAL_BITS),
        .NUM_COINS  (NUM_COINS),
        .INV_BITS   (INV_BITS)
    ) u_pick (
        .remaining  (remaining_reg),
        .inv_flat   (inv_flat),
        .pick       (pick),
        .found      (found)
    );

    always_comb begin
        sel_value = '0;
        for (int i = 0; i < NUM_COINS; i++) begin
            if (hop_sel_reg[i]) begin
                sel_value = sel_value | TOTAL_BITS'(coin_value(i));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg     <= ST_IDLE;
            remaining_reg <= '0;
            hop_valid_reg <= 1'b0;
            hop_sel_reg   <= '0;
            req_ready_reg <= 1'b1;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            shortfall_reg <= '0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (i_req_valid) begin
                        remaining_reg <= i_req_amount;
                        req_ready_reg <= 1'b0;
                        busy_reg      <= 1'b1;
                        state_reg     <= ST_SELECT;
                    end
                end
                ST_SELECT: begin
                    if (remaining_reg == '0 || !found) begin
                        shortfall_reg <= remaining_reg;
                        done_reg      <= 1'b1;
                        state_reg     <= ST_DONE;
                    end else begin
                        hop_sel_reg   <= pick;
                        hop_valid_reg <= 1'b1;
                        state_reg     <= ST_DISPENSE;
                    end
                end
                ST_DISPENSE: begin
                    if (i_hop_ack) begin
                        remaining_reg <= remaining_reg - sel_value;
                        hop_valid_reg <= 1'b0;
                        hop_sel_reg   <= '0;
                        state_reg     <= ST_SELECT;
                    end else if (jam) begin
                        hop_valid_reg <= 1'b0;
                        hop_sel_reg   <= '0;
                        state_reg     <= ST_SELECT;
                    end
                end
                ST_DONE: begin
                    req_ready_reg <= 1'b1;
                    busy_reg      <= 1'b0;
                    state_reg     <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign o_req_ready = req_ready_reg;
    assign o_hop_valid = hop_valid_reg;
    assign o_hop_sel   = hop_sel_reg;
    assign o_busy      = busy_reg;
    assign o_done      = done_reg;
    assign o_shortfall = shortfall_reg;

endmodule

// File: tb/tb_change_dispense_ctrl.sv
// Directed bench for change_dispense_ctrl with an inventory/payout model that
// computes coin lists by division; CHANGE_DISPENSE_TIMEOUT_EN adds the jam case.
module tb_change_dispense_ctrl;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        i_req_valid = 1'b0;
    logic        o_req_ready;
    logic [30:0] i_req_amount = '0;
    logic        o_hop_valid;
    logic [2:0]  o_hop_sel;
    logic        i_hop_ack = 1'b0;
    logic        i_refill_valid = 1'b0;
    logic [2:0]  i_refill_sel = '0;
    logic [7:0]  i_refill_count = '0;
    logic        o_busy;
    logic        o_done;
    logic [30:0] o_shortfall;
    logic [2:0]  o_inv_empty;
    logic        o_hop_fault;

    int checks = 0;
    int errors = 0;
    bit running = 1'b0;
    int val[3] = '{100, 500, 1000};
    int inv_m[3];
    int obs[$];

    always #5 clk = ~clk;

    change_dispense_ctrl dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .i_req_valid    (i_req_valid),
        .o_req_ready    (o_req_ready),
        .i_req_amount   (i_req_amount),
        .o_hop_valid    (o_hop_valid),
        .o_hop_sel      (o_hop_sel),
        .i_hop_ack      (i_hop_ack),
        .i_refill_valid (i_refill_valid),
        .i_refill_sel   (i_refill_sel),
        .i_refill_count (i_refill_count),
        .o_busy         (o_busy),
        .o_done         (o_done),
        .o_shortfall    (o_shortfall),
        .o_inv_empty    (o_inv_empty),
        .o_hop_fault    (o_hop_fault)
    );

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: wait bound expired at %0t", name, $time);
    endtask

    function automatic int sat(input int v);
        return (v > 255) ? 255 : v;
    endfunction

    function automatic logic [2:0] model_empty();
        logic [2:0] e;
        for (int d = 0; d < 3; d++) e[d] = (inv_m[d] == 0);
        return e;
    endfunction

    // Greedy payout by division: as many of each coin as fit, largest first.
    task automatic build_list(input int amount, output int lst[$], output int short);
        int rem;
        int n;
        rem = amount;
        lst = {};
        for (int d = 2; d >= 0; d--) begin
            n = rem / val[d];
            if (n > inv_m[d]) n = inv_m[d];
            for (int j = 0; j < n; j++) lst.push_back(d);
            rem -= n * val[d];
        end
        short = rem;
    endtask

    task automatic send_req(input int amount);
        @(negedge clk);
        check("req_ready_idle", o_req_ready, 1);
        i_req_valid  = 1'b1;
        i_req_amount = 31'(amount);
        @(posedge clk);
        #1;
        i_req_valid = 1'b0;
    endtask

    task automatic refill(input logic [2:0] sel, input int cnt);
        @(negedge clk);
        i_refill_valid = 1'b1;
        i_refill_sel   = sel;
        i_refill_count = 8'(cnt);
        @(posedge clk);
        #1;
        i_refill_valid = 1'b0;
        if ($onehot(sel)) begin
            for (int d = 0; d < 3; d++) if (sel[d]) inv_m[d] = sat(inv_m[d] + cnt);
        end
        $display("refill sel=%b count=%0d -> model inv %0d/%0d/%0d", sel, cnt, inv_m[0], inv_m[1], inv_m[2]);
    endtask

    task automatic serve(input int amount, input int ack_delay, input int refill_cnt, input bit do_send);
        int  lst[$];
        int  short;
        int  cyc;
        bit  got;
        bit  first;
        int  exp_d;
        build_list(amount, lst, short);
        obs.delete();
        first = do_send;
        if (do_send) send_req(amount);
        for (int k = 0; k < 400; k++) begin
            cyc = 0;
            got = 1'b0;
            while (!got && cyc < 40) begin
                @(negedge clk);
                cyc++;
                if (o_hop_valid || o_done) got = 1'b1;
            end
            if (!got) begin
                fail("hop_or_done_wait");
                return;
            end
            if (first) check("first_latency", cyc, 2);
            first = 1'b0;
            if (o_done) begin
                check("coins_left", lst.size(), 0);
                check("shortfall", o_shortfall, short);
                $display("request %0d: %0d coins, shortfall %0d", amount, obs.size(), o_shortfall);
                return;
            end
            if (lst.size() == 0) begin
                check("extra_coin_sel", o_hop_sel, 0);
                return;
            end
            exp_d = lst.pop_front();
            obs.push_back(int'(o_hop_sel));
            check("busy_dispense", o_busy, 1);
            check("hop_sel", o_hop_sel, 1 << exp_d);
            for (int w = 0; w < ack_delay; w++) begin
                @(negedge clk);
                check("hold_valid", o_hop_valid, 1);
                check("hold_sel", o_hop_sel, 1 << exp_d);
            end
            i_hop_ack = 1'b1;
            if (refill_cnt > 0 && k == 0) begin
                i_refill_valid = 1'b1;
                i_refill_sel   = 3'(1 << exp_d);
                i_refill_count = 8'(refill_cnt);
            end
            @(posedge clk);
            #1;
            i_hop_ack      = 1'b0;
            i_refill_valid = 1'b0;
            inv_m[exp_d]--;
            if (refill_cnt > 0 && k == 0) inv_m[exp_d] = sat(inv_m[exp_d] + refill_cnt);
        end
        fail("serve_loop");
    endtask

    task automatic check_obs(input string name, input int exp[$]);
        check({name, "_len"}, obs.size(), exp.size());
        for (int i = 0; i < exp.size() && i < obs.size(); i++) check(name, obs[i], exp[i]);
    endtask

    // Per-cycle comparison of observable inventory state against the model.
    always @(negedge clk) begin
        if (running && reset_n) begin
            check("inv_empty", o_inv_empty, model_empty());
`ifndef CHANGE_DISPENSE_TIMEOUT_EN
            check("hop_fault_idle", o_hop_fault, 0);
`endif
        end
    end

    initial begin
        int e[$];
        int cyc;
        int n;
        for (int d = 0; d < 3; d++) inv_m[d] = 10;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        running = 1'b1;
        @(negedge clk);
        check("rst_ready", o_req_ready, 1);
        check("rst_busy", o_busy, 0);
        check("rst_hop_valid", o_hop_valid, 0);
        check("rst_hop_sel", o_hop_sel, 0);
        check("rst_done", o_done, 0);
        check("rst_shortfall", o_shortfall, 0);
        check("rst_inv_empty", o_inv_empty, 3'b000);

        serve(1700, 0, 0, 1);
        e = '{4, 2, 1, 1};
        check_obs("seq_1700", e);
        check("sf_1700", o_shortfall, 0);

        serve(9000, 0, 0, 1);
        check("len_9000", obs.size(), 9);
        check("empty_1000", o_inv_empty, 3'b100);

        serve(1000, 0, 0, 1);
        e = '{2, 2};
        check_obs("seq_1000", e);

        serve(250, 0, 0, 1);
        e = '{1, 1};
        check_obs("seq_250", e);
        check("sf_250", o_shortfall, 50);

        serve(600, 5, 0, 1);
        e = '{2, 1};
        check_obs("seq_600_slow", e);

        serve(3500, 0, 0, 1);
        check("len_3500", obs.size(), 11);
        check("sf_3500", o_shortfall, 0);
        check("all_empty", o_inv_empty, 3'b111);

        serve(100, 0, 0, 1);
        check("sf_no_stock", o_shortfall, 100);
        serve(0, 0, 0, 1);
        check("sf_zero", o_shortfall, 0);

        refill(3'b011, 5);
        refill(3'b000, 5);
        @(negedge clk);
        check("bad_refill_ignored", o_inv_empty, 3'b111);

        refill(3'b001, 10);
        serve(100, 0, 3, 1);
        serve(1300, 0, 0, 1);
        check("len_1300", obs.size(), 12);
        check("sf_1300", o_shortfall, 100);

        refill(3'b001, 250);
        refill(3'b001, 250);
        serve(25600, 0, 0, 1);
        check("len_sat", obs.size(), 255);
        check("sf_sat", o_shortfall, 100);

        refill(3'b100, 1);
        send_req(1000);
        cyc = 0;
        while (!o_hop_valid && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        if (!o_hop_valid) fail("reset_test_valid");
        reset_n = 1'b0;
        @(posedge clk);
        #1 reset_n = 1'b1;
        for (int d = 0; d < 3; d++) inv_m[d] = 10;
        @(negedge clk);
        check("midrst_hop_valid", o_hop_valid, 0);
        check("midrst_ready", o_req_ready, 1);
        check("midrst_busy", o_busy, 0);
        check("midrst_shortfall", o_shortfall, 0);
        check("midrst_inv_empty", o_inv_empty, 3'b000);
        $display("mid-dispense reset: hop_valid=%0d ready=%0d", o_hop_valid, o_req_ready);

`ifdef CHANGE_DISPENSE_TIMEOUT_EN
        send_req(1000);
        cyc = 0;
        while (!o_hop_valid && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        if (!o_hop_valid) fail("timeout_test_valid");
        n = 1;
        while (n < 40) begin
            @(posedge clk);
            #1;
            if (!o_hop_valid) break;
            n++;
        end
        check("timeout_cycles", n, 16);
        check("hop_fault_pulse", o_hop_fault, 1);
        inv_m[2] = 0;
        $display("timeout: valid cycles=%0d fault=%0d", n, o_hop_fault);
        serve(1000, 0, 0, 0);
        e = '{2, 2};
        check_obs("seq_after_jam", e);
`else
        n = 0;
`endif

        running = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/change_dispense_ctrl.md
Name: change_dispense_ctrl

Overview:
Sequences physical coin return for the vending machine. It accepts a change amount through a valid/ready request, then pays it out with a greedy algorithm, highest denomination first. Coins are issued one at a time to the coin hopper over a valid/ack handshake. The block tracks a per-denomination coin inventory and reports any amount it could not pay.

Parameters:
TOTAL_BITS, 31, width of amounts (matches kTotalBits)
NUM_COINS, 3, number of denominations (matches kNumCoins)
INV_BITS, 8, width of each inventory counter
INIT_INV, 10, inventory value of every denomination after reset
TIMEOUT_CYCLES, 16, hopper ack timeout (used only with the optional feature)

Ports:
clk  in  1  clock
reset_n  in  1  synchronous active-low reset
i_req_valid  in  1  change request valid
o_req_ready  out  1  high only in IDLE
i_req_amount  in  TOTAL_BITS  amount to return, sampled on handshake
o_hop_valid  out  1  coin dispense request to hopper
o_hop_sel  out  NUM_COINS  one-hot denomination; bit0=100, bit1=500, bit2=1000
i_hop_ack  in  1  hopper has dropped the coin
i_refill_valid  in  1  refill strobe
i_refill_sel  in  NUM_COINS  one-hot denomination being refilled
i_refill_count  in  INV_BITS  coins added
o_busy  out  1  high in any state except IDLE
o_done  out  1  one-cycle pulse when a request completes
o_shortfall  out  TOTAL_BITS  unpaid remainder; valid with o_done, held until the next o_done
o_inv_empty  out  NUM_COINS  bit set when that inventory is 0
o_hop_fault  out  1  one-cycle timeout pulse

Behaviour:
- Reset, synchronous with reset_n low at a clk edge:
  - FSM goes to IDLE; remaining amount = 0.
  - All inventories = INIT_INV.
  - o_hop_valid=0, o_hop_sel=0, o_done=0, o_shortfall=0, o_hop_fault=0, o_busy=0, o_req_ready=1.
  - Reset mid-dispense drops o_hop_valid in the next cycle. The in-flight coin is not decremented.
- FSM states: IDLE, SELECT, DISPENSE, DONE.
- IDLE:
  - o_req_ready=1.
  - On i_req_valid, latch i_req_amount into remaining and go to SELECT.
- SELECT (exactly one cycle):
  - Pick the highest denomination d with inventory[d]>0 and remaining>=value[d].
  - If remaining==0: go to DONE with shortfall 0.
  - Else if no d qualifies: go to DONE with shortfall=remaining.
  - Else: register o_hop_sel=onehot(d) and go to DISPENSE.
- DISPENSE:
  - o_hop_valid=1; o_hop_sel holds stable until ack.
  - On i_hop_ack: remaining -= value[d], inventory[d] -= 1, go to SELECT.
  - Ack is allowed in the first DISPENSE cycle. Ack outside DISPENSE is ignored.
- DONE (one cycle):
  - o_done=1; o_shortfall is updated in this cycle; then go to IDLE.
- Latency: handshake accepted at edge T → o_hop_valid high from T+2 (cycle after SELECT). Back-to-back coins are separated by one SELECT cycle. Zero-amount request → o_done at T+2.
- Arithmetic:
  - Remaining never underflows; selection guarantees remaining>=value.
  - Amounts that are not multiples of 100 leave the remainder as shortfall.
- Refill:
  - Accepted in any state.
  - inventory[sel] += count, saturating at 2^INV_BITS−1.
  - Refill and ack on the same denomination in the same cycle: net = inv + count − 1, saturating.
  - i_refill_sel that is not one-hot (0 or multi-bit) is ignored.
  - Refill of a coin already selected in SELECT does not change the choice.
- o_inv_empty is combinational from the inventory registers.

Optional Feature:
CHANGE_DISPENSE_TIMEOUT_EN
- With the macro:
  - A counter runs while in DISPENSE.
  - If no ack arrives within TIMEOUT_CYCLES cycles, drop o_hop_valid and pulse o_hop_fault.
  - Force inventory[d]=0 (denomination treated as jammed) and return to SELECT, so payout continues with smaller coins.
  - The counter clears on entry to DISPENSE.
- Without the macro:
  - Wait for ack indefinitely.
  - o_hop_fault is tied 0; no counter is synthesized.

Decomposition:
- Shared package: coin values 100/500/1000, NUM_COINS, TOTAL_BITS, and the FSM state typedef/encoding.
- Sub-module change_coin_pick: combinational greedy selector. Inputs are remaining and the inventories; outputs are one-hot pick and a found flag.

Test Plan:
1. Amount 1700, full inventory → o_hop_sel sequence 100b, 010b, 001b, 001b; o_done with shortfall 0; inventories 100:8, 500:9, 1000:9.
2. Drain the 1000 inventory to 0, then request 1000 → 010b, 010b; shortfall 0; o_inv_empty[2]=1.
3. Amount 250 → 001b, 001b; o_done with shortfall 50.
4. Ack withheld for 5 cycles → o_hop_valid and o_hop_sel stable throughout; exactly one decrement after ack.
5. Refill 100-coin with count 3 in the same cycle as a 100-coin ack, inventory 10 → 12. Refill 250 onto 250 → saturates at 255.
6. reset_n low during DISPENSE → next cycle o_hop_valid=0, IDLE, all inventories 10. With CHANGE_DISPENSE_TIMEOUT_EN and no ack: o_hop_fault after 16 cycles, that denomination's inventory = 0.
